// File: rtl/asrv32_bus_arbiter.sv
// asrv32_bus_arbiter
// Shares one single-port memory bus between the instruction-fetch and
// load/store ports of the core. Each access moves through IDLE -> BUSY -> DONE.
// Every output comes from a register, so there is no combinational path from
// any input to any output. A BUSY access that receives no memory ack within
// TIMEOUT_CYCLES cycles completes with rdata=0 and a bus-error pulse.
`timescale 1ns/1ps

module asrv32_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic        o_inst_ack,
    output logic [31:0] o_inst_rdata,
    input  logic        i_data_req,
    input  logic        i_data_wr,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    input  logic [3:0]  i_data_mask,
    output logic        o_data_ack,
    output logic [31:0] o_data_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wr_mask,
    output logic        o_mem_wr_en,
    output logic        o_mem_rd_en,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_bus_error
);

    // The counter is wide enough to hold TIMEOUT_CYCLES-1 and is never narrower than one bit.
    localparam int CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state,      w_state;
    logic             r_last_grant, w_last_grant;  // 1 = data port was granted last
    logic             r_owner,      w_owner;       // 1 = data port owns the current access
    logic [CNT_W-1:0] r_cnt,        w_cnt;
    logic [31:0]      r_mem_addr,   w_mem_addr;
    logic [31:0]      r_mem_wdata,  w_mem_wdata;
    logic [3:0]       r_mem_mask,   w_mem_mask;
    logic             r_mem_wr_en,  w_mem_wr_en;
    logic             r_mem_rd_en,  w_mem_rd_en;
    logic             r_inst_ack,   w_inst_ack;
    logic [31:0]      r_inst_rdata, w_inst_rdata;
    logic             r_data_ack,   w_data_ack;
    logic [31:0]      r_data_rdata, w_data_rdata;
    logic             r_bus_error,  w_bus_error;

    logic             w_pick_data;
    logic             w_timeout;

    // Data wins when it is the only requester, or under contention when the fetch port was granted last.
    assign w_pick_data = i_data_req & (~i_inst_req | ~r_last_grant);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    // Next-state and next-output logic; every registered value holds unless changed below.
    always_comb begin
        w_state      = r_state;
        w_last_grant = r_last_grant;
        w_owner      = r_owner;
        w_cnt        = r_cnt;
        w_mem_addr   = r_mem_addr;
        w_mem_wdata  = r_mem_wdata;
        w_mem_mask   = r_mem_mask;
        w_mem_wr_en  = r_mem_wr_en;
        w_mem_rd_en  = r_mem_rd_en;
        w_inst_rdata = r_inst_rdata;
        w_data_rdata = r_data_rdata;
        w_inst_ack   = 1'b0;
        w_data_ack   = 1'b0;
        w_bus_error  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_inst_req || i_data_req) begin
                    w_cnt   = '0;
                    w_state = S_BUSY;
                    if (w_pick_data) begin
                        w_owner      = 1'b1;
                        w_last_grant = 1'b1;
                        w_mem_addr   = i_data_addr;
                        w_mem_wdata  = i_data_wdata;
                        w_mem_mask   = i_data_mask;
                        w_mem_wr_en  = i_data_wr;
                        w_mem_rd_en  = ~i_data_wr;
                    end else begin
                        w_owner      = 1'b0;
                        w_last_grant = 1'b0;
                        w_mem_addr   = i_inst_addr;
                        w_mem_wdata  = 32'h0;
                        w_mem_mask   = 4'b0000;
                        w_mem_wr_en  = 1'b0;
                        w_mem_rd_en  = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (i_mem_ack) begin
                    w_mem_wr_en = 1'b0;
                    w_mem_rd_en = 1'b0;
                    w_state     = S_DONE;
                    if (r_owner) begin
                        w_data_rdata = r_mem_wr_en ? 32'h0 : i_mem_rdata;
                        w_data_ack   = 1'b1;
                    end else begin
                        w_inst_rdata = i_mem_rdata;
                        w_inst_ack   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_mem_wr_en = 1'b0;
                    w_mem_rd_en = 1'b0;
                    w_bus_error = 1'b1;
                    w_state     = S_DONE;
                    if (r_owner) begin
                        w_data_rdata = 32'h0;
                        w_data_ack   = 1'b1;
                    end else begin
                        w_inst_rdata = 32'h0;
                        w_inst_ack   = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            S_DONE: begin
                // The ack pulse is already on the outputs; requests are not looked at here.
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces everything to 0 and the fetch port as last granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b0;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_mask   <= 4'b0000;
            r_mem_wr_en  <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_inst_ack   <= 1'b0;
            r_inst_rdata <= 32'h0;
            r_data_ack   <= 1'b0;
            r_data_rdata <= 32'h0;
            r_bus_error  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_last_grant <= w_last_grant;
            r_owner      <= w_owner;
            r_cnt        <= w_cnt;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_mem_mask   <= w_mem_mask;
            r_mem_wr_en  <= w_mem_wr_en;
            r_mem_rd_en  <= w_mem_rd_en;
            r_inst_ack   <= w_inst_ack;
            r_inst_rdata <= w_inst_rdata;
            r_data_ack   <= w_data_ack;
            r_data_rdata <= w_data_rdata;
            r_bus_error  <= w_bus_error;
        end
    end

    assign o_inst_ack    = r_inst_ack;
    assign o_inst_rdata  = r_inst_rdata;
    assign o_data_ack    = r_data_ack;
    assign o_data_rdata  = r_data_rdata;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_wr_mask = r_mem_mask;
    assign o_mem_wr_en   = r_mem_wr_en;
    assign o_mem_rd_en   = r_mem_rd_en;
    assign o_bus_error   = r_bus_error;

endmodule

// File: tb/tb_asrv32_bus_arbiter.sv
// tb_asrv32_bus_arbiter
// Directed test of the bus arbiter with a 4-cycle timeout. Inputs change and
// outputs are sampled 1ns after each rising edge. Expected values are worked
// out by hand from the cycle-by-cycle protocol.
`timescale 1ns/1ps

module tb_asrv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_mask;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_error;

    int n_vec = 0;
    int n_err = 0;

    asrv32_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_inst_req   (inst_req),
        .i_inst_addr  (inst_addr),
        .o_inst_ack   (inst_ack),
        .o_inst_rdata (inst_rdata),
        .i_data_req   (data_req),
        .i_data_wr    (data_wr),
        .i_data_addr  (data_addr),
        .i_data_wdata (data_wdata),
        .i_data_mask  (data_mask),
        .o_data_ack   (data_ack),
        .o_data_rdata (data_rdata),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wr_mask(mem_wr_mask),
        .o_mem_wr_en  (mem_wr_en),
        .o_mem_rd_en  (mem_rd_en),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ack    (mem_ack),
        .o_bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flattened view of every output so the all-zero condition is one comparison.
    function automatic logic [31:0] out_or();
        return inst_rdata | data_rdata | mem_addr | mem_wdata |
               {25'h0, mem_wr_mask, mem_wr_en, mem_rd_en, 1'b0} |
               {29'h0, inst_ack, data_ack, bus_error};
    endfunction

    task automatic check_zero_outputs(input string tag);
        check_vec({tag, "_or"}, out_or(), 32'h0);
        check_vec({tag, "_ctl"}, {27'h0, inst_ack, data_ack, bus_error, mem_wr_en, mem_rd_en}, 32'h0);
    endtask

    // Load on the data port, acked in the cycle after the strobe appears.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] rdata);
        data_req = 1'b1; data_wr = 1'b0; data_addr = addr; data_mask = 4'hF;
        tick();
        check_vec({tag, "_rd_en"}, {31'h0, mem_rd_en}, 32'h1);
        check_vec({tag, "_addr"},  mem_addr, addr);
        mem_ack = 1'b1; mem_rdata = rdata;
        tick();
        mem_ack = 1'b0; data_req = 1'b0;
        check_vec({tag, "_ack"},   {31'h0, data_ack}, 32'h1);
        check_vec({tag, "_rdata"}, data_rdata, rdata);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = 32'h0;
        data_wdata = 32'h0; data_mask = 4'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        #1;
        check_zero_outputs("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ---- fetch at 0x100, memory acks in the strobe cycle
        inst_req = 1'b1; inst_addr = 32'h100;
        tick();
        check_vec("fetch_rd_en", {31'h0, mem_rd_en}, 32'h1);
        check_vec("fetch_wr_en", {31'h0, mem_wr_en}, 32'h0);
        check_vec("fetch_addr",  mem_addr, 32'h100);
        check_vec("fetch_mask",  {28'h0, mem_wr_mask}, 32'h0);
        check_vec("fetch_wdata", mem_wdata, 32'h0);
        check_vec("fetch_noack", {31'h0, inst_ack}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h00000013;
        tick();
        mem_ack = 1'b0; inst_req = 1'b0;
        check_vec("fetch_ack",   {31'h0, inst_ack}, 32'h1);
        check_vec("fetch_rdata", inst_rdata, 32'h13);
        check_vec("fetch_err",   {31'h0, bus_error}, 32'h0);
        check_vec("fetch_dack",  {31'h0, data_ack}, 32'h0);
        check_vec("fetch_strobe_off", {31'h0, mem_rd_en}, 32'h0);
        tick();
        check_vec("fetch_ack_1cyc", {31'h0, inst_ack}, 32'h0);

        // ---- load so the following store has a nonzero rdata to clear
        do_load("load1", 32'h3000, 32'hCAFEF00D);

        // ---- store, memory acks on the third strobe cycle
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h2004;
        data_wdata = 32'hDEADBEEF; data_mask = 4'b0011;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_vec($sformatf("store_wr_en_c%0d", c), {30'h0, mem_wr_en, mem_rd_en}, 32'h2);
            check_vec($sformatf("store_addr_c%0d", c),  mem_addr, 32'h2004);
            check_vec($sformatf("store_wdata_c%0d", c), mem_wdata, 32'hDEADBEEF);
            check_vec($sformatf("store_mask_c%0d", c),  {28'h0, mem_wr_mask}, 32'h3);
            check_vec($sformatf("store_noack_c%0d", c), {31'h0, data_ack}, 32'h0);
        end
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0; data_req = 1'b0;
        check_vec("store_ack",    {31'h0, data_ack}, 32'h1);
        check_vec("store_rdata",  data_rdata, 32'h0);
        check_vec("store_err",    {31'h0, bus_error}, 32'h0);
        check_vec("store_wr_off", {31'h0, mem_wr_en}, 32'h0);
        check_vec("inst_rdata_hold", inst_rdata, 32'h13);
        tick();
        check_vec("store_ack_1cyc", {31'h0, data_ack}, 32'h0);

        // ---- load, then a load that times out after 4 BUSY cycles
        do_load("load2", 32'h3010, 32'h55AA55AA);
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h4000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_vec($sformatf("tmo_rd_en_c%0d", c), {31'h0, mem_rd_en}, 32'h1);
            check_vec($sformatf("tmo_noack_c%0d", c), {30'h0, data_ack, bus_error}, 32'h0);
        end
        tick();
        data_req = 1'b0;
        check_vec("tmo_rd_off", {31'h0, mem_rd_en}, 32'h0);
        check_vec("tmo_ack",    {31'h0, data_ack}, 32'h1);
        check_vec("tmo_err",    {31'h0, bus_error}, 32'h1);
        check_vec("tmo_rdata",  data_rdata, 32'h0);
        tick();
        check_vec("tmo_pulse_1cyc", {30'h0, data_ack, bus_error}, 32'h0);

        // ---- same load, ack arrives in the 4th BUSY cycle: normal completion
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h4004;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_vec($sformatf("late_rd_en_c%0d", c), {31'h0, mem_rd_en}, 32'h1);
        end
        mem_ack = 1'b1; mem_rdata = 32'h00000077;
        tick();
        mem_ack = 1'b0; data_req = 1'b0;
        check_vec("late_ack",   {31'h0, data_ack}, 32'h1);
        check_vec("late_err",   {31'h0, bus_error}, 32'h0);
        check_vec("late_rdata", data_rdata, 32'h77);
        tick();

        // ---- contention: both requests held from reset, data must win first
        rst_n = 1'b0;
        #1;
        inst_req = 1'b1; inst_addr = 32'h200;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h5000;
        tick(); tick();
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            logic        exp_data;
            logic [31:0] exp_addr;
            logic [31:0] exp_rdata;
            exp_data  = (g % 2 == 0);
            exp_addr  = exp_data ? 32'h5000 : 32'h200;
            exp_rdata = 32'hA000_0000 + 32'(g);
            tick();
            check_vec($sformatf("cont%0d_rd_en", g), {31'h0, mem_rd_en}, 32'h1);
            check_vec($sformatf("cont%0d_addr", g),  mem_addr, exp_addr);
            mem_ack = 1'b1; mem_rdata = exp_rdata;
            tick();
            mem_ack = 1'b0;
            check_vec($sformatf("cont%0d_acks", g), {30'h0, inst_ack, data_ack},
                      exp_data ? 32'h1 : 32'h2);
            check_vec($sformatf("cont%0d_rdata", g), exp_data ? data_rdata : inst_rdata, exp_rdata);
            tick();
            check_vec($sformatf("cont%0d_idle", g), {29'h0, inst_ack, data_ack, mem_rd_en}, 32'h0);
        end
        inst_req = 1'b0; data_req = 1'b0;
        tick(); tick(); tick();

        // ---- reset in the middle of a pending store
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h6000;
        data_wdata = 32'hFEEDFACE; data_mask = 4'b1100;
        tick();
        check_vec("rstmid_wr_en", {31'h0, mem_wr_en}, 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("rstmid_async");
        data_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mem_ack = (c == 1) || (c == 3);
            tick();
            check_vec($sformatf("rstmid_quiet_c%0d", c),
                      {27'h0, inst_ack, data_ack, bus_error, mem_wr_en, mem_rd_en}, 32'h0);
        end
        mem_ack = 1'b0;
        // An idle arbiter issues a new fetch on the very next cycle.
        inst_req = 1'b1; inst_addr = 32'h300;
        tick();
        check_vec("rstmid_idle_rd_en", {31'h0, mem_rd_en}, 32'h1);
        check_vec("rstmid_idle_addr",  mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'hBBBB0001;
        tick();
        mem_ack = 1'b0; inst_req = 1'b0;
        check_vec("rstmid_fetch_ack", {31'h0, inst_ack}, 32'h1);
        check_vec("rstmid_fetch_rdata", inst_rdata, 32'hBBBB0001);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/asrv32_bus_arbiter.md
ASRV32_BUS_ARBITER -- requirements
Module: asrv32_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning max cycles in BUSY awaiting i_mem_ack; 0 disables the timeout.
REQ-002 SHALL have ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_inst_req  in  1  instruction-fetch request.
- i_inst_addr  in  32  fetch address.
- o_inst_ack  out  1  one-cycle completion pulse, fetch.
- o_inst_rdata  out  32  fetched word, valid with o_inst_ack.
- i_data_req  in  1  load/store request.
- i_data_wr  in  1  1=store, 0=load.
- i_data_addr  in  32  data address.
- i_data_wdata  in  32  store data.
- i_data_mask  in  4  store byte mask {b3,b2,b1,b0}.
- o_data_ack  out  1  one-cycle completion pulse, data.
- o_data_rdata  out  32  load word, valid with o_data_ack.
- o_mem_addr  out  32  shared memory address.
- o_mem_wdata  out  32  shared memory write data.
- o_mem_wr_mask  out  4  shared memory byte mask.
- o_mem_wr_en  out  1  write strobe, held until i_mem_ack.
- o_mem_rd_en  out  1  read strobe, held until i_mem_ack.
- i_mem_rdata  in  32  memory read data, valid with i_mem_ack.
- i_mem_ack  in  1  memory completion, one cycle.
- o_bus_error  out  1  one-cycle pulse, coincident with the ack of a timed-out access.
REQ-003 SHALL register all outputs; no input-to-output combinational path.

Function
REQ-004 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-005 IDLE: if any req is high, SHALL grant one requester, latch its addr/wdata/mask into o_mem_*, and assert o_mem_rd_en (load/fetch) or o_mem_wr_en (store); next state BUSY. If no req is high, SHALL stay in IDLE.
REQ-006 Fetch grant SHALL drive o_mem_wr_mask=4'b0000 and o_mem_wdata=0.
REQ-007 Arbitration SHALL be round-robin using a last_grant bit: if both reqs are high, the requester not granted last wins. A sole requester always wins and updates last_grant.
REQ-008 BUSY: o_mem_* SHALL stay stable. On i_mem_ack, SHALL capture i_mem_rdata to the owner's rdata (stores: rdata=0), deassert strobes, and go to DONE.
REQ-009 BUSY timeout: a counter clears on entry and increments each BUSY cycle without i_mem_ack. On reaching TIMEOUT_CYCLES, SHALL deassert strobes, set owner rdata=0, set bus_error pending, and go to DONE. i_mem_ack in the same cycle SHALL take precedence (normal completion, no error).
REQ-010 DONE: SHALL pulse the owner's ack (plus o_bus_error if pending) for exactly one cycle, ignore all reqs, and return to IDLE.
REQ-011 Requester protocol: req and its address/data SHALL stay stable until ack; req low in the ack cycle. The arbiter never samples reqs in BUSY or DONE, so a single request is never serviced twice.
REQ-012 Latency: req seen in IDLE at cycle 0 -> strobe at cycle 1. i_mem_ack at cycle k (k>=1) -> ack at cycle k+1. Minimum issue-to-issue spacing is 3 cycles.
REQ-013 o_inst_rdata/o_data_rdata SHALL hold their last value until that requester's next completion.
REQ-014 i_mem_ack in IDLE or DONE SHALL be ignored.

Reset
REQ-015 On i_rst_n low, at any time including mid-access, SHALL asynchronously set: state=IDLE, last_grant=inst (data wins the first contention), counter=0, and all outputs 0. The abandoned access SHALL NOT be acked after reset release.

Verification
REQ-016 Fetch: inst_req, addr=0x100; mem acks cycle 1, rdata=0x00000013 -> o_mem_rd_en cycle 1, o_inst_ack=1 with rdata=0x13 cycle 2, error=0.
REQ-017 Store: data_req, wr=1, addr=0x2004, wdata=0xDEADBEEF, mask=4'b0011; mem acks after 3 cycles -> wr_en held 3 cycles with stable bus, single o_data_ack, o_data_rdata=0.
REQ-018 Contention: both reqs held from reset -> grants data, inst, data, inst; each ack single-cycle; no duplicate service.
REQ-019 Timeout: TIMEOUT_CYCLES=4, load with no i_mem_ack -> strobe drops after 4 BUSY cycles; o_data_ack and o_bus_error pulse together; rdata=0. Repeat with ack in the 4th cycle -> no error.
REQ-020 Reset mid-BUSY: assert i_rst_n low during a pending store -> all outputs 0 immediately; after release with no reqs, no ack and state IDLE.
